// File: rtl/instr_fetch_stage.sv
// MIPS IF stage: PC generation, single-outstanding valid/ready fetch, and the IF/ID register.
// Optional macro IF_PERF_CNT_EN adds fetch and stall performance counters.
module instr_fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                id_stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                if_id_valid,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc_plus_4,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt,
`endif
  output logic [1:0]          dbg_state
);

  // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // while waiting for ready, valid stays high and imem_addr stays stable (redirect excepted).
  // Responses return in order, one per accepted request, flagged by imem_rsp_valid.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n;
  logic [31:0]         hold_instr, hold_instr_n;
  logic [PC_WIDTH-1:0] hold_pc4, hold_pc4_n;
  logic                load_en;
  logic [31:0]         load_instr;
  logic [PC_WIDTH-1:0] load_pc4;
  logic                accept;
  logic [PC_WIDTH-1:0] redirect_aligned;

  assign imem_req_valid   = (state == S_REQ) && !reset;
  assign imem_addr        = pc;
  assign accept           = imem_req_valid && imem_req_ready;
  assign redirect_aligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign dbg_state        = state;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    hold_instr_n = hold_instr;
    hold_pc4_n   = hold_pc4;
    load_en      = 1'b0;
    load_instr   = imem_rsp_data;
    load_pc4     = pc;  // pc already advanced past the outstanding fetch
    case (state)
      S_REQ: begin
        if (accept) begin
          pc_n    = pc + PC_WIDTH'(4);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (!if_id_valid || !id_stall) begin
            load_en = 1'b1;
            state_n = S_REQ;
          end else begin
            hold_instr_n = imem_rsp_data;
            hold_pc4_n   = pc;
            state_n      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!id_stall) begin
          load_en    = 1'b1;
          load_instr = hold_instr;
          load_pc4   = hold_pc4;
          state_n    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
    // Redirect wins over everything; a request still in flight must be drained in S_DROP.
    if (redirect_valid) begin
      pc_n         = redirect_aligned;
      load_en      = 1'b0;
      hold_instr_n = '0;
      hold_pc4_n   = '0;
      if ((state == S_WAIT && !imem_rsp_valid) ||
          (state == S_REQ  && accept) ||
          (state == S_DROP && !imem_rsp_valid))
        state_n = S_DROP;
      else
        state_n = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_REQ;
      pc              <= RESET_PC;
      hold_instr      <= '0;
      hold_pc4        <= '0;
      if_id_valid     <= 1'b0;
      if_id_instr     <= '0;
      if_id_pc_plus_4 <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      hold_instr <= hold_instr_n;
      hold_pc4   <= hold_pc4_n;
      if (load_en) begin
        if_id_valid     <= 1'b1;
        if_id_instr     <= load_instr;
        if_id_pc_plus_4 <= load_pc4;
      end else if (redirect_valid || !id_stall) begin
        if_id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load_en)                 perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_id_valid && id_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: reset, streaming fetch, stall/hold, ready backpressure,
// redirect with stale-response drop, PC wrap, and reset during an outstanding fetch.
module tb_instr_fetch_stage;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus_4;
  logic [1:0]  dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int passes = 0;

  instr_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .id_stall        (id_stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus_4 (if_id_pc_plus_4),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h20080005;
    return 32'h8C000000 | a;
  endfunction

  // One full fetch from S_REQ with a 1-cycle memory and decode not stalled.
  task automatic do_fetch(input logic [31:0] a);
    logic [31:0] d;
    logic [31:0] p4;
    d  = mem_word(a);
    p4 = a + 32'd4;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== a)
      $display("FAIL fetch_req: valid=%b addr=%h, expected valid=1 addr=%h", imem_req_valid, imem_addr, a);
    else passes++;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    checks++;
    if (imem_req_valid !== 1'b0)
      $display("FAIL fetch_wait_req: valid=%b, expected 0", imem_req_valid);
    else passes++;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== d || if_id_pc_plus_4 !== p4)
      $display("FAIL fetch_ifid @%h: valid=%b instr=%h pc4=%h, expected 1 %h %h",
               a, if_id_valid, if_id_instr, if_id_pc_plus_4, d, p4);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc_plus_4 !== 32'h0 || dbg_state !== ST_REQ)
      $display("FAIL reset_state: req=%b v=%b instr=%h pc4=%h st=%0d, expected 0 0 0 0 0",
               imem_req_valid, if_id_valid, if_id_instr, if_id_pc_plus_4, dbg_state);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL reset_first_req: valid=%b addr=%h, expected 1 00000000", imem_req_valid, imem_addr);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h0);
    do_fetch(32'h4);
    do_fetch(32'h8);
  endtask

  // IF/ID holds instr@8; stall across the next fetch so it lands in the hold buffer.
  task automatic test_stall();
    id_stall = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(32'hC);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    checks++;
    if (dbg_state !== ST_HOLD || if_id_instr !== mem_word(32'h8) || if_id_pc_plus_4 !== 32'hC ||
        if_id_valid !== 1'b1)
      $display("FAIL stall_hold: st=%0d instr=%h pc4=%h v=%b, expected 2 %h 0000000c 1",
               dbg_state, if_id_instr, if_id_pc_plus_4, if_id_valid, mem_word(32'h8));
    else passes++;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b0 || if_id_instr !== mem_word(32'h8) || if_id_pc_plus_4 !== 32'hC)
        $display("FAIL stall_frozen[%0d]: req=%b instr=%h pc4=%h, expected 0 %h 0000000c",
                 i, imem_req_valid, if_id_instr, if_id_pc_plus_4, mem_word(32'h8));
      else passes++;
    end
    imem_req_ready = 1'b0;
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd5)
      $display("FAIL perf_stall: got %0d, expected 5", perf_stall_cnt);
    else passes++;
`endif
    id_stall = 1'b0;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'hC) || if_id_pc_plus_4 !== 32'h10 ||
        dbg_state !== ST_REQ || imem_addr !== 32'h10)
      $display("FAIL stall_release: v=%b instr=%h pc4=%h st=%0d addr=%h, expected 1 %h 00000010 0 00000010",
               if_id_valid, if_id_instr, if_id_pc_plus_4, dbg_state, imem_addr, mem_word(32'hC));
    else passes++;
    tick();
    checks++;
    if (if_id_valid !== 1'b0)
      $display("FAIL stall_consumed: v=%b, expected 0", if_id_valid);
    else passes++;
  endtask

  task automatic test_ready_low();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10)
        $display("FAIL ready_low[%0d]: valid=%b addr=%h, expected 1 00000010", i, imem_req_valid, imem_addr);
      else passes++;
    end
    do_fetch(32'h10);
  endtask

  task automatic test_redirect();
    id_stall = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    checks++;
    if (if_id_valid !== 1'b0 || dbg_state !== ST_DROP || imem_req_valid !== 1'b0)
      $display("FAIL redirect_flush: v=%b st=%0d req=%b, expected 0 3 0", if_id_valid, dbg_state, imem_req_valid);
    else passes++;
    id_stall = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    checks++;
    if (if_id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40)
      $display("FAIL redirect_drop: v=%b req=%b addr=%h, expected 0 1 00000040", if_id_valid, imem_req_valid, imem_addr);
    else passes++;
    do_fetch(32'h40);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    checks++;
    if (imem_addr !== 32'hFFFFFFFC || dbg_state !== ST_REQ || if_id_valid !== 1'b0)
      $display("FAIL wrap_redirect: addr=%h st=%0d v=%b, expected fffffffc 0 0", imem_addr, dbg_state, if_id_valid);
    else passes++;
    do_fetch(32'hFFFFFFFC);
    checks++;
    if (imem_addr !== 32'h0)
      $display("FAIL wrap_next_addr: got %h, expected 00000000", imem_addr);
    else passes++;
  endtask

  task automatic test_reset_mid_fetch();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    checks++;
    if (dbg_state !== ST_WAIT)
      $display("FAIL rstmid_wait: st=%0d, expected 1", dbg_state);
    else passes++;
    reset = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc_plus_4 !== 32'h0 || dbg_state !== ST_REQ)
      $display("FAIL rstmid_state: req=%b v=%b instr=%h pc4=%h st=%0d, expected 0 0 0 0 0",
               imem_req_valid, if_id_valid, if_id_instr, if_id_pc_plus_4, dbg_state);
    else passes++;
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("FAIL rstmid_perf: fetch=%0d stall=%0d, expected 0 0", perf_fetch_cnt, perf_stall_cnt);
    else passes++;
`endif
    reset = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBADBAD00;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    checks++;
    if (if_id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL rstmid_stale: v=%b req=%b addr=%h, expected 0 1 00000000", if_id_valid, imem_req_valid, imem_addr);
    else passes++;
    do_fetch(32'h0);
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'd1)
      $display("FAIL perf_fetch: got %0d, expected 1", perf_fetch_cnt);
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_ready_low();
    test_redirect();
    test_wrap();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
